// File: rtl/key_trig_pkg.sv
// Shared FSM state type and key-level helper for the key_trig debouncer.
package key_trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        P_DEB = 2'd1,
        HELD  = 2'd2,
        R_DEB = 2'd3
    } state_e;

    // Idle (released) level of the raw key for a given active level.
    function automatic logic key_released(input logic key_act);
        return ~key_act;
    endfunction

endpackage

// File: rtl/key_trig_if.sv
// Key input / trigger output bundle; master drives the key, slave is the debouncer.
interface key_trig_if;
    logic key_in;
    logic en;
    logic key_state;

    modport master (output key_in, input en, input key_state);
    modport slave  (input key_in, output en, output key_state);
endinterface

// File: rtl/key_trig_sync_2ff.sv
// Two-flop synchroniser with a parameterised reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_trig.sv
// Debounced key-press trigger: one registered en pulse per accepted press plus a debounced level.
// Optional auto-repeat while held is enabled by defining AUTO_REPEAT_EN.
module key_trig
    import key_trig_pkg::*;
#(
    parameter int unsigned DEB_CYC    = 1_000_000,
    parameter logic        KEY_ACT    = 1'b0,
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_CYC = 5_000_000
) (
    input logic       clk,
    input logic       rst,
    key_trig_if.slave kif
);

    localparam int unsigned CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    if (DEB_CYC < 2 || REPEAT_DLY < 1 || REPEAT_CYC < 1) begin : g_bad_param
        $error("key_trig: DEB_CYC must be >= 2 and repeat periods >= 1");
    end

    logic   sync_key;
    logic   pressed;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             key_state_q, key_state_d;

    sync_2ff #(
        .RST_VAL(key_released(KEY_ACT))
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (kif.key_in),
        .q  (sync_key)
    );

    assign pressed = (sync_key == KEY_ACT);

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC;
    localparam int unsigned REP_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DLY - 1);
    localparam logic [REP_W-1:0] CYC_LAST = REP_W'(REPEAT_CYC - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_d        = 1'b0;
        key_state_d = key_state_q;

        case (state_q)
            IDLE: begin
                if (pressed) state_d = P_DEB;
            end
            P_DEB: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    en_d        = 1'b1;
                    key_state_d = 1'b1;
                end
            end
            HELD: begin
                if (!pressed) state_d = R_DEB;
            end
            R_DEB: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    key_state_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == P_DEB || state_q == R_DEB) begin
            cnt_d = cnt_q + 1'b1;
        end

`ifdef AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        // Repeat timing only advances across cycles that stay in HELD; any entry or exit restarts the delay phase.
        if (state_q == HELD && state_d == HELD) begin
            if (rep_cnt_q == (rep_phase_q ? CYC_LAST : DLY_LAST)) begin
                en_d        = 1'b1;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end else begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            key_state_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            key_state_q <= key_state_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

    assign kif.en        = en_q;
    assign kif.key_state = key_state_q;

endmodule
